// File: rtl/dvid_pkg.sv
// Shared constants for the DVI TMDS channel encoders: word and disparity
// widths plus the four control-period codes.
package dvid_pkg;

  localparam int TMDS_W = 10;
  localparam int CNT_W  = 5;

  localparam logic [TMDS_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/tmds_popcount8.sv
// Number of set bits in an 8-bit vector, used for both the input byte and
// the transition-minimised byte.
module tmds_popcount8 (
  input  logic [7:0] in_bits,
  output logic [3:0] count
);

  // adder chain over the eight input bits
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, in_bits[i]};
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b channel encoder: stage 1 minimises transitions,
// stage 2 applies DC balance against a signed running disparity.
module tmds_encoder
  import dvid_pkg::*;
(
  input  logic              clk_pixel,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic [1:0]        in_c,
  input  logic              in_blank,
  output logic [TMDS_W-1:0] out_tmds,
  output logic              out_blank
);

  logic [3:0]              n1d_s;
  logic [3:0]              n1q_s;
  logic [8:0]              qm_d, qm_q;
  logic [1:0]              c_d, c_q;
  logic                    blank1_d, blank1_q;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic [TMDS_W-1:0]       tmds_d, tmds_q;
  logic                    blank2_d, blank2_q;

  logic signed [CNT_W:0]   diff_s;
  logic signed [CNT_W:0]   cnt_ext_s;
  logic signed [CNT_W:0]   cnt_next_s;

  tmds_popcount8 u_pop_d (.in_bits(in_data),   .count(n1d_s));
  tmds_popcount8 u_pop_q (.in_bits(qm_q[7:0]), .count(n1q_s));

  // stage 1: choose XOR or XNOR chaining and carry control alongside
  always_comb begin
    logic use_xnor;
    logic [8:0] qm_v;
    use_xnor = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && !in_data[0]);
    qm_v = 9'd0;
    qm_v[0] = in_data[0];
    for (int i = 1; i < 8; i++) begin
      qm_v[i] = use_xnor ? ~(qm_v[i-1] ^ in_data[i]) : (qm_v[i-1] ^ in_data[i]);
    end
    qm_v[8]  = ~use_xnor;
    qm_d     = qm_v;
    c_d      = in_c;
    blank1_d = in_blank;
  end

  // stage 2: DC balance; diff is n1q - n0q, widened so the sum never wraps
  always_comb begin
    diff_s     = $signed({1'b0, n1q_s, 1'b0}) - 6'sd8;
    cnt_ext_s  = {cnt_q[CNT_W-1], cnt_q};
    tmds_d     = CTRL_00;
    cnt_next_s = 6'sd0;
    blank2_d   = blank1_q;
    if (blank1_q) begin
      case (c_q)
        2'b00:   tmds_d = CTRL_00;
        2'b01:   tmds_d = CTRL_01;
        2'b10:   tmds_d = CTRL_10;
        2'b11:   tmds_d = CTRL_11;
        default: tmds_d = CTRL_00;
      endcase
      cnt_next_s = 6'sd0;
    end else if ((cnt_q == 5'sd0) || (diff_s == 6'sd0)) begin
      tmds_d     = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_next_s = qm_q[8] ? (cnt_ext_s + diff_s) : (cnt_ext_s - diff_s);
    end else if (cnt_q[CNT_W-1] == diff_s[CNT_W]) begin
      // both non-zero here, so equal sign bits mean cnt and diff agree in sign
      tmds_d     = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_next_s = cnt_ext_s + (qm_q[8] ? 6'sd2 : 6'sd0) - diff_s;
    end else begin
      tmds_d     = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_next_s = cnt_ext_s - (qm_q[8] ? 6'sd0 : 6'sd2) + diff_s;
    end
    cnt_d = cnt_next_s[CNT_W-1:0];
  end

  // pipeline registers; reset makes both stages look like a 00 control period
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      qm_q     <= 9'd0;
      c_q      <= 2'b00;
      blank1_q <= 1'b1;
      cnt_q    <= 5'sd0;
      tmds_q   <= CTRL_00;
      blank2_q <= 1'b1;
    end else begin
      qm_q     <= qm_d;
      c_q      <= c_d;
      blank1_q <= blank1_d;
      cnt_q    <= cnt_d;
      tmds_q   <= tmds_d;
      blank2_q <= blank2_d;
    end
  end

  assign out_tmds  = tmds_q;
  assign out_blank = blank2_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed vectors with hand-computed
// words and disparity, then a long random stream against a behavioural model.
module tb_tmds_encoder;
  import dvid_pkg::*;

  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] in_data   = 8'h00;
  logic [1:0] in_c      = 2'b00;
  logic       in_blank  = 1'b1;
  logic [9:0] out_tmds;
  logic       out_blank;

  tmds_encoder dut (
    .clk_pixel(clk_pixel),
    .reset    (reset),
    .in_data  (in_data),
    .in_c     (in_c),
    .in_blank (in_blank),
    .out_tmds (out_tmds),
    .out_blank(out_blank)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] tmds;
    logic       blank;
    int         cnt;
    logic       chk_cnt;
    logic       chk_dec;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;

  function automatic logic [7:0] decode(input logic [9:0] w);
    logic [7:0] t;
    logic [7:0] r;
    t = w[9] ? ~w[7:0] : w[7:0];
    r[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
    return r;
  endfunction

  task automatic model_step(input logic rst, input logic bl, input logic [1:0] c,
                            input logic [7:0] d, output logic [9:0] w);
    int n1d, n1, n0;
    logic xn, q8;
    logic [7:0] qm;
    if (rst) begin
      w = CTRL_00;
      m_cnt = 0;
    end else if (bl) begin
      case (c)
        2'b00:   w = 10'b1101010100;
        2'b01:   w = 10'b0010101011;
        2'b10:   w = 10'b0101010100;
        default: w = 10'b1010101011;
      endcase
      m_cnt = 0;
    end else begin
      n1d = 0;
      for (int i = 0; i < 8; i++) if (d[i]) n1d++;
      xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      q8 = ~xn;
      n1 = 0;
      for (int i = 0; i < 8; i++) if (qm[i]) n1++;
      n0 = 8 - n1;
      if (m_cnt == 0 || n1 == n0) begin
        w = {~q8, q8, q8 ? qm : ~qm};
        m_cnt = q8 ? m_cnt + n1 - n0 : m_cnt + n0 - n1;
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
        w = {1'b1, q8, ~qm};
        m_cnt = m_cnt + (q8 ? 2 : 0) + n0 - n1;
      end else begin
        w = {1'b0, q8, qm};
        m_cnt = m_cnt - (q8 ? 0 : 2) + n1 - n0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic bl, input logic [1:0] c,
                       input logic [7:0] d, input logic hand,
                       input logic [9:0] hw, input int hcnt);
    exp_t e;
    exp_t old;
    logic [9:0] mw;
    @(posedge clk_pixel);
    #2;
    reset = rst; in_blank = bl; in_c = c; in_data = d;
    if (rst && sb.size() > 0 && sb[$].due == cyc + 1) begin
      old = sb.pop_back();
      old.tmds = CTRL_00; old.blank = 1'b1; old.cnt = 0;
      old.chk_cnt = 1'b1; old.chk_dec = 1'b0;
      sb.push_back(old);
    end
    model_step(rst, bl, c, d, mw);
    e.tmds    = hand ? hw : mw;
    e.cnt     = hand ? hcnt : m_cnt;
    e.blank   = rst | bl;
    e.chk_cnt = 1'b1;
    e.chk_dec = !rst && !bl;
    e.data    = d;
    e.due     = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic rst_cyc();
    drive(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, CTRL_00, 0);
  endtask
  task automatic ctl(input logic [1:0] c, input logic [9:0] w);
    drive(1'b0, 1'b1, c, 8'h00, 1'b1, w, 0);
  endtask
  task automatic pix(input logic [7:0] d, input logic [9:0] w, input int cn);
    drive(1'b0, 1'b0, 2'b00, d, 1'b1, w, cn);
  endtask
  task automatic rnd_pix(input logic [7:0] d);
    drive(1'b0, 1'b0, 2'b00, d, 1'b0, 10'd0, 0);
  endtask
  task automatic rnd_ctl(input logic [1:0] c);
    drive(1'b0, 1'b1, c, 8'h00, 1'b0, 10'd0, 0);
  endtask

  // monitor: disparity bound every cycle, then pop whatever is due now
  initial begin
    exp_t e;
    int act_cnt;
    forever begin
      @(negedge clk_pixel);
      act_cnt = int'(dut.cnt_q);
      checks++;
      if (act_cnt > 10 || act_cnt < -10) begin
        errors++;
        $display("FAIL cnt_range cyc=%0d got=%0d want=[-10,10]", cyc, act_cnt);
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.due < cyc) begin
          errors++;
          $display("FAIL missed_slot cyc=%0d got=late want=%0d", cyc, e.due);
        end else begin
          if (out_tmds !== e.tmds || out_blank !== e.blank) begin
            errors++;
            $display("FAIL word cyc=%0d got=%b/%b want=%b/%b",
                     cyc, out_tmds, out_blank, e.tmds, e.blank);
          end
          if (e.chk_cnt) begin
            checks++;
            if (act_cnt != e.cnt) begin
              errors++;
              $display("FAIL cnt cyc=%0d got=%0d want=%0d", cyc, act_cnt, e.cnt);
            end
          end
          if (e.chk_dec) begin
            checks++;
            if (decode(out_tmds) !== e.data) begin
              errors++;
              $display("FAIL decode cyc=%0d got=%h want=%h", cyc, decode(out_tmds), e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (4) rst_cyc();
    ctl(2'b00, 10'b1101010100);
    ctl(2'b00, 10'b1101010100);
    ctl(2'b01, 10'b0010101011);
    ctl(2'b10, 10'b0101010100);
    ctl(2'b11, 10'b1010101011);

    pix(8'h00, 10'b0100000000, -8);
    pix(8'h00, 10'b1111111111,  2);
    pix(8'h00, 10'b0100000000, -6);
    pix(8'h00, 10'b1111111111,  4);

    ctl(2'b00, 10'b1101010100);
    pix(8'hFF, 10'b1000000000, -8);
    pix(8'hFF, 10'b0011111111, -2);

    ctl(2'b00, 10'b1101010100);
    pix(8'h00, 10'b0100000000, -8);
    pix(8'h00, 10'b1111111111,  2);
    pix(8'h00, 10'b0100000000, -6);
    ctl(2'b00, 10'b1101010100);
    pix(8'h00, 10'b0100000000, -8);

    rnd_pix(8'h55);
    rnd_pix(8'hA3);
    rst_cyc();
    rst_cyc();
    ctl(2'b00, 10'b1101010100);
    pix(8'h00, 10'b0100000000, -8);

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 15) == 0) rnd_ctl(2'($urandom_range(0, 3)));
      else rnd_pix(8'($urandom_range(0, 255)));
    end

    repeat (4) @(posedge clk_pixel);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
